// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares one single-ported synchronous memory between the instruction-fetch
// (IF) requester and the load/store (DM) requester. Every access walks
// IDLE -> ISSUE -> [WAIT] -> CAPTURE -> RESP, one access at a time.
// Data requests win ties in IDLE.
// Optional feature macro: FETCH_STARVATION_GUARD_EN. When it is defined, IF
// gets priority after three DM grants that were made while IF was waiting.
module memory_port_arbiter #(
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 64,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_address,
   output logic                  if_ready,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_write,
   input  logic [ADDR_WIDTH-1:0] dm_address,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_ready,
   output logic                  dm_rvalid,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

   // The ISSUE cycle accounts for one cycle of latency.
   // WAIT covers the remaining MEM_LATENCY-1 cycles.
   localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

   state_t                state_reg;
   logic [3:0]            wait_cnt_reg;
   logic                  owner_dm_reg;
   logic                  write_reg;
   logic                  if_rvalid_reg;
   logic                  dm_rvalid_reg;
   logic                  busy_reg;
   logic                  mem_en_reg;
   logic                  mem_we_reg;
   logic [ADDR_WIDTH-1:0] mem_address_reg;
   logic [DATA_WIDTH-1:0] mem_wdata_reg;
   logic [DATA_WIDTH-1:0] if_rdata_reg;
   logic [DATA_WIDTH-1:0] dm_rdata_reg;

   logic                  if_priority;
   logic                  in_idle;
   logic                  if_grant;
   logic                  dm_grant;

`ifdef FETCH_STARVATION_GUARD_EN
   logic [1:0]            starve_cnt_reg;

   assign if_priority = (starve_cnt_reg == 2'd3);

   // Count DM grants that left a waiting fetch behind.
   // The count saturates at 3, and any fetch grant clears it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_reg <= '0;
      end else if (if_grant) begin
         starve_cnt_reg <= '0;
      end else if (dm_grant && if_req && (starve_cnt_reg != 2'd3)) begin
         starve_cnt_reg <= starve_cnt_reg + 2'd1;
      end
   end
`else
   assign if_priority = 1'b0;
`endif

   // Grants are combinational and only possible in IDLE.
   // Data wins unless the fetch side has been starved.
   assign in_idle  = (state_reg == IDLE) && !reset;
   assign dm_grant = in_idle && dm_req && !(if_priority && if_req);
   assign if_grant = in_idle && if_req && !dm_grant;

   assign if_ready    = if_grant;
   assign dm_ready    = dm_grant;
   assign if_rvalid   = if_rvalid_reg;
   assign dm_rvalid   = dm_rvalid_reg;
   assign if_rdata    = if_rdata_reg;
   assign dm_rdata    = dm_rdata_reg;
   assign mem_en      = mem_en_reg;
   assign mem_we      = mem_we_reg;
   assign mem_address = mem_address_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign busy        = busy_reg;

   // Access sequencer: latch the winning request, drive the memory pins for
   // exactly one cycle, count out the latency, capture the data and pulse
   // rvalid to the owner.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         wait_cnt_reg    <= '0;
         owner_dm_reg    <= 1'b0;
         write_reg       <= 1'b0;
         if_rvalid_reg   <= 1'b0;
         dm_rvalid_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         mem_en_reg      <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_address_reg <= '0;
         mem_wdata_reg   <= '0;
         if_rdata_reg    <= '0;
         dm_rdata_reg    <= '0;
      end else begin
         // Memory pins and response pulses are single-cycle.
         // They are cleared by default and set only on the cycle before they apply.
         mem_en_reg      <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_address_reg <= '0;
         mem_wdata_reg   <= '0;
         if_rvalid_reg   <= 1'b0;
         dm_rvalid_reg   <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (dm_grant || if_grant) begin
                  owner_dm_reg    <= dm_grant;
                  write_reg       <= dm_grant && dm_write;
                  mem_en_reg      <= 1'b1;
                  mem_we_reg      <= dm_grant && dm_write;
                  mem_address_reg <= dm_grant ? dm_address : if_address;
                  mem_wdata_reg   <= dm_grant ? dm_wdata : '0;
                  busy_reg        <= 1'b1;
                  state_reg       <= ISSUE;
               end
            end

            ISSUE: begin
               wait_cnt_reg <= WAIT_LOAD;
               state_reg    <= (WAIT_LOAD != 4'd0) ? WAIT : CAPTURE;
            end

            WAIT: begin
               wait_cnt_reg <= wait_cnt_reg - 4'd1;
               if (wait_cnt_reg == 4'd1) begin
                  state_reg <= CAPTURE;
               end
            end

            CAPTURE: begin
               // A store has no read data, so dm_rdata keeps its last load value.
               if (!owner_dm_reg) begin
                  if_rdata_reg <= mem_rdata;
               end else if (!write_reg) begin
                  dm_rdata_reg <= mem_rdata;
               end
               if_rvalid_reg <= !owner_dm_reg;
               dm_rvalid_reg <= owner_dm_reg;
               state_reg     <= RESP;
            end

            RESP: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
